// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the load/store unit.
// Imported by load_store_unit and lsu_byte_lane.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ACCESS    = 2'd1,
      S_RMW_WRITE = 2'd2,
      S_RESP      = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Load extraction/extension and sub-word store merge for one 32-bit word.
// Purely combinational.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] rd_word,
   input  logic [31:0] merge_word,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      unique case (lane)
         2'd0: b = rd_word[7:0];
         2'd1: b = rd_word[15:8];
         2'd2: b = rd_word[23:16];
         2'd3: b = rd_word[31:24];
      endcase
      h = lane[1] ? rd_word[31:16] : rd_word[15:0];
      case (funct3)
         F3_B:    ld_data = {{24{b[7]}}, b};
         F3_BU:   ld_data = {24'd0, b};
         F3_H:    ld_data = {{16{h[15]}}, h};
         F3_HU:   ld_data = {16'd0, h};
         default: ld_data = rd_word;
      endcase
   end

   always_comb begin
      st_data = merge_word;
      if (funct3 == F3_B) begin
         unique case (lane)
            2'd0: st_data[7:0]   = wdata[7:0];
            2'd1: st_data[15:8]  = wdata[7:0];
            2'd2: st_data[23:16] = wdata[7:0];
            2'd3: st_data[31:24] = wdata[7:0];
         endcase
      end else if (lane[1]) begin
         st_data[31:16] = wdata[15:0];
      end else begin
         st_data[15:0] = wdata[15:0];
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word access over a word-only memory.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned half/word as errors.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        rst_in,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam logic [29:0] IDX_LIM = 30'(MEM_WORDS);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] merge_q, merge_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        rvalid_q, rvalid_d;

   logic        f3_bad, oor, mis, err_c;
   logic [31:0] ld_data, st_data;

   lsu_byte_lane u_lane (
      .funct3     (f3_q),
      .lane       (addr_q[1:0]),
      .rd_word    (mem_rd),
      .merge_word (merge_q),
      .wdata      (wdata_q),
      .ld_data    (ld_data),
      .st_data    (st_data)
   );

   always_comb begin
      if (we_q) f3_bad = !(f3_q inside {F3_B, F3_H, F3_W});
      else      f3_bad = !(f3_q inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      oor = addr_q[31:2] >= IDX_LIM;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = ((f3_q == F3_H || f3_q == F3_HU) && addr_q[0]) ||
            (f3_q == F3_W && addr_q[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      err_c = f3_bad || oor || mis;
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      f3_d     = f3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      merge_d  = merge_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      rvalid_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (err_c || !we_q || f3_q == F3_W) begin
               err_d    = err_c;
               rdata_d  = (err_c || we_q) ? 32'd0 : ld_data;
               rvalid_d = 1'b1;
               state_d  = S_RESP;
            end else begin
               merge_d = mem_rd;
               state_d = S_RMW_WRITE;
            end
         end
         S_RMW_WRITE: begin
            err_d    = 1'b0;
            rdata_d  = 32'd0;
            rvalid_d = 1'b1;
            state_d  = S_RESP;
         end
         S_RESP: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_in) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         f3_q     <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         merge_q  <= 32'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         f3_q     <= f3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         merge_q  <= merge_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Write strobe gated by reset so an abandoned request never commits.
   logic sw_go;
   assign sw_go     = state_q == S_ACCESS && we_q && f3_q == F3_W && !err_c;
   assign mem_we    = rst_in && (sw_go || state_q == S_RMW_WRITE);
   assign mem_wd    = sw_go ? wdata_q :
                      (state_q == S_RMW_WRITE) ? st_data : 32'd0;
   assign mem_a     = {2'b00, addr_q[31:2]};
   assign req_ready = state_q == S_IDLE;
   assign rsp_valid = rvalid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic
// against a word-array reference model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_in = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic [31:0] mem [32];
   logic [31:0] ref_mem [32];
   int total = 0;
   int bad = 0;
   int acc_cnt = 0;
   logic [31:0] last_rdata;
   logic        last_err;

   load_store_unit #(.MEM_WORDS(32)) dut (
      .clk(clk), .rst_in(rst_in),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   always_comb mem_rd = (mem_a < 32) ? mem[mem_a[4:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_we && mem_a < 32) mem[mem_a[4:0]] <= mem_wd;
      if (rst_in && req_valid && req_ready) acc_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_word(input int i, input logic [31:0] v);
      mem[i] = v;
      ref_mem[i] = v;
   endtask

   task automatic txn(input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit hold);
      logic [29:0] wi;
      logic [31:0] ea, w, x, mask, e_rdata;
      bit legal, is_half, is_word, e_err, seen;
      int sh, e_lat, e_we, lat, wecnt, acc0;
      wi = a[31:2];
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      is_half = f3[1:0] == 2'b01;
      is_word = f3[1:0] == 2'b10;
      e_err = !legal || wi >= 32 ||
              (TRAP && ((is_half && a[0]) || (is_word && a[1:0] != 0)));
      ea = a;
      if (is_half) ea[0] = 1'b0;
      if (is_word) ea[1:0] = 2'b00;
      sh = 8 * int'(ea[1:0]);
      e_rdata = 32'd0;
      if (!e_err && !we) begin
         w = ref_mem[wi[4:0]];
         if (is_word) x = w;
         else if (is_half) x = (w >> sh) & 32'hFFFF;
         else x = (w >> sh) & 32'hFF;
         if (f3 == 3'd0 && x >= 32'h80) x = x | 32'hFFFFFF00;
         if (f3 == 3'd1 && x >= 32'h8000) x = x | 32'hFFFF0000;
         e_rdata = x;
      end
      e_lat = (!e_err && we && !is_word) ? 3 : 2;
      e_we  = (!e_err && we) ? 1 : 0;

      @(negedge clk);
      acc0 = acc_cnt;
      check("ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_we = we;
      req_funct3 = f3;
      req_addr = a;
      req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      seen = 0; lat = 0; wecnt = 0;
      for (int k = 1; k <= 8 && !seen; k++) begin
         if (k > 1) @(negedge clk);
         if (mem_we) wecnt++;
         if (rsp_valid) begin
            seen = 1; lat = k;
            last_rdata = rsp_rdata;
            last_err = rsp_err;
         end
      end
      req_valid = 1'b0;
      check("latency", lat, e_lat);
      check("we_cycles", wecnt, e_we);
      if (seen) begin
         check("rdata", last_rdata, e_rdata);
         check("err", {31'd0, last_err}, {31'd0, e_err});
      end
      @(negedge clk);
      check("pulse", {31'd0, rsp_valid}, 32'd0);
      check("accepts", acc_cnt - acc0, 1);

      if (!e_err && we) begin
         if (is_word) begin
            ref_mem[wi[4:0]] = wd;
         end else begin
            mask = (is_half ? 32'hFFFF : 32'hFF) << sh;
            ref_mem[wi[4:0]] = (ref_mem[wi[4:0]] & ~mask) | ((wd << sh) & mask);
         end
      end
   endtask

   initial begin
      bit noisy;
      for (int i = 0; i < 32; i++) set_word(i, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rvalid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", {31'd0, rsp_err}, 32'd0);
      check("rst_we", {31'd0, mem_we}, 32'd0);
      check("rst_a", mem_a, 32'd0);
      check("rst_wd", mem_wd, 32'd0);
      rst_in = 1'b1;

      set_word(2, 32'h00000008);
      txn(1'b0, 3'b010, 32'h8, 32'h0, 1'b0);
      check("lw8", last_rdata, 32'h00000008);

      set_word(0, 32'hAAAAAAAA);
      txn(1'b0, 3'b000, 32'h3, 32'h0, 1'b0);
      check("lb3", last_rdata, 32'hFFFFFFAA);
      txn(1'b0, 3'b100, 32'h3, 32'h0, 1'b0);
      check("lbu3", last_rdata, 32'h000000AA);
      txn(1'b0, 3'b101, 32'h2, 32'h0, 1'b0);
      check("lhu2", last_rdata, 32'h0000AAAA);

      set_word(1, 32'h0);
      txn(1'b1, 3'b000, 32'h5, 32'h12345677, 1'b0);
      check("sb_mem", mem[1], 32'h00007700);

      txn(1'b1, 3'b001, 32'h1, 32'h0000BEEF, 1'b0);
      check("sh_mis_err", {31'd0, last_err}, {31'd0, TRAP});
      check("sh_mis_mem", mem[0], TRAP ? 32'hAAAAAAAA : 32'hAAAABEEF);

      // Reset during the ACCESS cycle of a byte store.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h4; req_wdata = 32'h000000FF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("rmw_rst_we", {31'd0, mem_we}, 32'd0);
      rst_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
      check("rmw_rst_rvalid", {31'd0, rsp_valid}, 32'd0);
      check("rmw_rst_rdata", rsp_rdata, 32'd0);
      check("rmw_rst_err", {31'd0, rsp_err}, 32'd0);
      check("rmw_rst_a", mem_a, 32'd0);
      check("rmw_rst_wd", mem_wd, 32'd0);
      rst_in = 1'b1;
      noisy = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid || mem_we) noisy = 1;
      end
      check("rmw_rst_quiet", {31'd0, noisy}, 32'd0);
      check("rmw_rst_mem", mem[1], ref_mem[1]);

      set_word(1, 32'h0BADF00D);
      txn(1'b0, 3'b010, 32'h4, 32'h0, 1'b1);
      txn(1'b0, 3'b010, 32'h80, 32'h0, 1'b1);
      check("oor_err", {31'd0, last_err}, 32'd1);

      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
         txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
             $urandom, 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 32; i++) check($sformatf("mem%0d", i), mem[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
